wam_spawner: RTL and testbench

WAM_SPAWNER -- requirements
Module: wam_spawner

---
 rtl/wam_spawner.sv | 136 +++++++++++++
 tb/tb_wam_spawner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wam_spawner.sv
// Whack-a-mole spawner: an 8-bit Galois LFSR picks spawn positions, each live
// mole carries an age counter that expires it after a programmable number of
// ticks, and saturating counters track hits and (optionally) misses.
// Build option: define WAM_MISS_CNT_EN to include the miss counter; without
// it miss_cnt is tied to zero and no miss register is built.
module wam_spawner #(
  parameter int NHOLES = 8,
  parameter int AGE_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              tick,
  input  logic              load,
  input  logic [7:0]        seed,
  input  logic [NHOLES-1:0] hit,
  input  logic [AGE_W-1:0]  age,
  input  logic [7:0]        rto,
  input  logic [3:0]        max_up,
  output logic [NHOLES-1:0] holes,
  output logic              spawn,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = (NHOLES > 1) ? $clog2(NHOLES) : 1;
  localparam int PC_W  = $clog2(NHOLES + 1);

  logic [7:0]        r_lfsr;
  logic [NHOLES-1:0] r_holes;
  logic [AGE_W-1:0]  r_age [NHOLES];
  logic              r_spawn;
  logic [CNT_W-1:0]  r_hit_cnt;

  logic [NHOLES-1:0] w_hit_clr;
  logic [NHOLES-1:0] w_expire;
  logic [NHOLES-1:0] w_remain;
  logic [PC_W-1:0]   w_hit_n;
  logic [PC_W-1:0]   w_live_after;
  logic [IDX_W-1:0]  w_start;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_target;
  logic              w_found;
  logic              w_do_spawn;
  logic [7:0]        w_lfsr_next;
  logic [CNT_W:0]    w_hit_sum;

  // Galois step: bit7 feeds back into bit0 and taps 4, 5 and 6.
  assign w_lfsr_next = {r_lfsr[6], r_lfsr[5] ^ r_lfsr[7], r_lfsr[4] ^ r_lfsr[7],
                        r_lfsr[3] ^ r_lfsr[7], r_lfsr[2:0], r_lfsr[7]};

  // Classify each hole this cycle (hit / expire / survive) and pick a spawn target.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    w_hit_clr  = hit & r_holes;
    w_expire   = '0;
    w_found    = 1'b0;
    w_target   = '0;
    w_idx      = '0;
    for (int i = 0; i < NHOLES; i++) begin
      // A hit wins over an expiry on the same hole.
      if (tick && r_holes[i] && !hit[i] && (r_age[i] == age)) w_expire[i] = 1'b1;
    end
    w_remain     = r_holes & ~w_hit_clr & ~w_expire;
    w_hit_n      = PC_W'($countones(w_hit_clr));
    w_live_after = PC_W'($countones(w_remain));
    // Search upward from r mod NHOLES with wrap; only holes empty before
    // this edge are eligible, so a hole freed this cycle is skipped.
    w_start = IDX_W'(int'(r_lfsr) % NHOLES);
    for (int k = 0; k < NHOLES; k++) begin
      w_idx = IDX_W'((int'(w_start) + k) % NHOLES);
      if (!w_found && !r_holes[w_idx]) begin
        w_found  = 1'b1;
        w_target = w_idx;
      end
    end
    w_do_spawn = tick && (r_lfsr < rto) && (int'(w_live_after) < int'(max_up)) && w_found;
    w_hit_sum  = {1'b0, r_hit_cnt} + (CNT_W + 1)'(w_hit_n);
  end

  // Mole board, age counters, LFSR, spawn pulse and hit score.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_lfsr    <= 8'h01;
      r_holes   <= '0;
      r_spawn   <= 1'b0;
      r_hit_cnt <= '0;
      // NOTE: the age array is reset explicitly because a stale age would shorten a future mole's life.
      for (int i = 0; i < NHOLES; i++) r_age[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (load)      r_lfsr <= (seed == 8'h00) ? 8'h01 : seed;
      else if (tick) r_lfsr <= w_lfsr_next;

      for (int i = 0; i < NHOLES; i++) begin
        if (w_hit_clr[i] || w_expire[i]) begin
          r_holes[i] <= 1'b0;
          r_age[i]   <= '0;
        end else if (tick && r_holes[i]) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
      // The target was empty before the edge, so it never collides with a clear above.
      if (w_do_spawn) begin
        r_holes[w_target] <= 1'b1;
        r_age[w_target]   <= '0;
      end
      r_spawn   <= w_do_spawn;
      r_hit_cnt <= w_hit_sum[CNT_W] ? '1 : w_hit_sum[CNT_W-1:0];
    end
  end

  assign holes   = r_holes;
  assign spawn   = r_spawn;
  assign hit_cnt = r_hit_cnt;

`ifdef WAM_MISS_CNT_EN
  logic [CNT_W-1:0] r_miss_cnt;
  logic [PC_W-1:0]  w_exp_n;
  logic [CNT_W:0]   w_miss_sum;

  assign w_exp_n    = PC_W'($countones(w_expire));
  assign w_miss_sum = {1'b0, r_miss_cnt} + (CNT_W + 1)'(w_exp_n);

  // Saturating count of moles that expired unhit.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_miss_cnt <= '0;
    else        r_miss_cnt <= w_miss_sum[CNT_W] ? '1 : w_miss_sum[CNT_W-1:0];
  end

  assign miss_cnt = r_miss_cnt;
`else
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_wam_spawner.sv
// Bench for wam_spawner: a behavioural model predicts each cycle's outputs,
// predictions are queued when stimulus is driven and compared one edge later,
// plus hand-derived directed checks for the documented scenarios.
module tb_wam_spawner;

  localparam int NH = 8;
`ifdef WAM_MISS_CNT_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr_n = 1'b1;
  logic          tick = 1'b0;
  logic          load = 1'b0;
  logic [7:0]    seed = '0;
  logic [NH-1:0] hit = '0;
  logic [3:0]    age = '0;
  logic [7:0]    rto = '0;
  logic [3:0]    max_up = '0;
  logic [NH-1:0] holes;
  logic          spawn;
  logic [7:0]    hit_cnt;
  logic [7:0]    miss_cnt;

  wam_spawner #(.NHOLES(NH), .AGE_W(4), .CNT_W(8)) dut (
    .clk(clk), .clr_n(clr_n), .tick(tick), .load(load), .seed(seed),
    .hit(hit), .age(age), .rto(rto), .max_up(max_up),
    .holes(holes), .spawn(spawn), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NH-1:0] holes;
    logic          spawn;
    int            hits;
    int            misses;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [7:0]    m_lfsr;
  logic [NH-1:0] m_holes;
  logic [3:0]    m_age [NH];
  logic          m_spawn;
  int            m_hit;
  int            m_miss;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr = 8'h01; m_holes = '0; m_spawn = 1'b0; m_hit = 0; m_miss = 0;
    for (int i = 0; i < NH; i++) m_age[i] = '0;
  endtask

  task automatic model_step(input logic t, input logic ld, input logic [7:0] sd,
                            input logic [NH-1:0] h);
    logic [7:0]    r;
    logic [NH-1:0] nxt;
    logic [3:0]    nage [NH];
    int            nh, nm, tgt, st, j;
    r = m_lfsr; nxt = m_holes; nh = 0; nm = 0; tgt = -1;
    for (int i = 0; i < NH; i++) begin
      nage[i] = m_age[i];
      if (m_holes[i]) begin
        if (h[i]) begin
          nxt[i] = 1'b0; nage[i] = '0; nh++;
        end else if (t) begin
          if (m_age[i] == age) begin nxt[i] = 1'b0; nage[i] = '0; nm++; end
          else nage[i] = m_age[i] + 4'd1;
        end
      end
    end
    if (t && (r < rto) && ($countones(nxt) < int'(max_up))) begin
      st = int'(r) % NH;
      for (int k = 0; k < NH; k++) begin
        j = (st + k) % NH;
        if (tgt < 0 && !m_holes[j]) tgt = j;
      end
    end
    if (tgt >= 0) begin nxt[tgt] = 1'b1; nage[tgt] = '0; end
    m_spawn = (tgt >= 0);
    m_holes = nxt;
    for (int i = 0; i < NH; i++) m_age[i] = nage[i];
    m_hit  = (m_hit + nh > 255) ? 255 : m_hit + nh;
    m_miss = (m_miss + nm > 255) ? 255 : m_miss + nm;
    if (ld) m_lfsr = (sd == 8'h00) ? 8'h01 : sd;
    else if (t) begin
      m_lfsr = {r[6:0], 1'b0};
      if (r[7]) m_lfsr = m_lfsr ^ 8'h71;
    end
  endtask

  // One clock of stimulus: drive at negedge, predict, compare after the posedge.
  task automatic step(input logic t, input logic ld, input logic [7:0] sd, input logic [NH-1:0] h);
    exp_t e;
    @(negedge clk);
    tick = t; load = ld; seed = sd; hit = h;
    model_step(t, ld, sd, h);
    e.holes = m_holes; e.spawn = m_spawn; e.hits = m_hit;
    e.misses = MISS_EN ? m_miss : 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("sb_holes", 32'(holes), 32'(e.holes));
      check("sb_spawn", 32'(spawn), 32'(e.spawn));
      check("sb_hit_cnt", 32'(hit_cnt), 32'(e.hits));
      check("sb_miss_cnt", 32'(miss_cnt), 32'(e.misses));
    end
    tick = 1'b0; load = 1'b0; hit = '0;
  endtask

  // Asynchronous assertion away from any clock edge, synchronous release.
  task automatic do_reset();
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    check("rst_holes", 32'(holes), 32'd0);
    check("rst_spawn", 32'(spawn), 32'd0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    int guard;
    model_reset();
    do_reset();

    // Seed 0 loads 8'h01; first mole in hole 1, later ones at 2 and 4; hole 1 expires on the 3rd later tick.
    age = 4'd2; rto = 8'd255; max_up = 4'd8;
    step(1'b0, 1'b1, 8'h00, '0);
    step(1'b1, 1'b0, 8'h00, '0);
    check("first_spawn_pulse", 32'(spawn), 32'd1);
    check("first_spawn_hole", 32'(holes), 32'h02);
    for (int n = 0; n < 3; n++) begin
      repeat (3) step(1'b0, 1'b0, 8'h00, '0);
      step(1'b1, 1'b0, 8'h00, '0);
    end
    check("expire_holes", 32'(holes), 32'h15);
    check("expire_miss", 32'(miss_cnt), MISS_EN ? 32'd1 : 32'd0);

    // Hit coinciding with an expiring tick counts only as a hit; hit on an empty hole is ignored.
    do_reset();
    age = 4'd0; rto = 8'd255; max_up = 4'd8;
    step(1'b0, 1'b1, 8'h03, '0);
    step(1'b1, 1'b0, 8'h00, '0);
    check("hole3_live", 32'(holes), 32'h08);
    step(1'b1, 1'b0, 8'h00, 8'h08);
    check("hit_vs_expire_holes", 32'(holes), 32'h40);
    check("hit_vs_expire_hits", 32'(hit_cnt), 32'd1);
    check("hit_vs_expire_miss", 32'(miss_cnt), 32'd0);
    step(1'b0, 1'b0, 8'h00, 8'h20);
    check("empty_hit_hits", 32'(hit_cnt), 32'd1);

    // max_up limit, then a hit on the tick frees room for a spawn elsewhere.
    do_reset();
    age = 4'd15; rto = 8'd255; max_up = 4'd2;
    step(1'b0, 1'b1, 8'h01, '0);
    step(1'b1, 1'b0, 8'h00, '0);
    step(1'b1, 1'b0, 8'h00, '0);
    step(1'b1, 1'b0, 8'h00, '0);
    check("max_up_block", 32'(spawn), 32'd0);
    step(1'b1, 1'b0, 8'h00, 8'h02);
    check("freed_spawn", 32'(spawn), 32'd1);
    check("freed_holes", 32'(holes), 32'h05);

    // rto=0 and max_up=0 never spawn.
    do_reset();
    age = 4'd3; rto = 8'd0; max_up = 4'd8;
    repeat (3) step(1'b1, 1'b0, 8'h00, '0);
    check("rto0_holes", 32'(holes), 32'd0);
    rto = 8'd255; max_up = 4'd0;
    repeat (3) step(1'b1, 1'b0, 8'h00, '0);
    check("maxup0_holes", 32'(holes), 32'd0);

    // Full board blocks spawning; hit counter saturates.
    do_reset();
    age = 4'd15; rto = 8'd255; max_up = 4'd15;
    step(1'b0, 1'b1, 8'h01, '0);
    repeat (8) step(1'b1, 1'b0, 8'h00, '0);
    check("board_full", 32'(holes), 32'hFF);
    step(1'b1, 1'b0, 8'h00, '0);
    check("full_no_spawn", 32'(spawn), 32'd0);
    guard = 0;
    while (m_hit < 255 && guard < 3000) begin
      step(1'b1, 1'b0, 8'h00, m_holes);
      guard++;
    end
    guard = 0;
    while (m_holes == '0 && guard < 20) begin
      step(1'b1, 1'b0, 8'h00, '0);
      guard++;
    end
    check("sat_have_mole", 32'(m_holes != '0), 32'd1);
    step(1'b0, 1'b0, 8'h00, m_holes);
    check("hit_saturate", 32'(hit_cnt), 32'd255);

    // Mid-game reset discards live moles and scores.
    do_reset();
    age = 4'd15; rto = 8'd255; max_up = 4'd8;
    repeat (4) step(1'b1, 1'b0, 8'h00, '0);
    do_reset();

    // Randomised play against the model.
    for (int c = 0; c < 600; c++) begin
      logic [NH-1:0] h;
      if (c % 50 == 0) begin
        age    = 4'($urandom_range(0, 3));
        rto    = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
        max_up = 4'($urandom_range(0, 15));
      end
      h = ($urandom_range(0, 1) == 0) ? (m_holes & 8'($urandom)) : (8'($urandom) & 8'($urandom));
      step($urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0, 8'($urandom), h);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
